// File: rtl/ibus_dbus_arb_pkg.sv
// Shared definitions for the I/D bus arbiter: FSM state type, source tags
// stored in the response tracker, and the saturating starve-count helper.
package ibus_dbus_arb_pkg;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StILock = 2'd1,
        StDLock = 2'd2
    } arb_state_e;

    // Source tags pushed into the tracker; the head tag steers responses.
    localparam logic ARB_SRC_I = 1'b0;
    localparam logic ARB_SRC_D = 1'b1;

    // Wide enough for the largest legal starve limit (15).
    localparam int unsigned STARVE_W = 4;

    function automatic logic [STARVE_W-1:0] starve_inc(input logic [STARVE_W-1:0] cnt);
        return (cnt == '1) ? cnt : cnt + 1'b1;
    endfunction

endpackage

// File: rtl/ibus_dbus_arb_fifo.sv
// Small synchronous FIFO used as the source-tag tracker.
// Ports:
//   clk_i, resetb_i  clock, asynchronous active-low reset
//   clk_en_i         all state holds when low
//   flush_i          empties the FIFO
//   push_i, wdata_i  write side (ignored when full)
//   pop_i, rdata_o   read side (ignored when empty), rdata_o shows the head entry
//   empty_o, full_o  occupancy flags
module ibus_dbus_arb_fifo #(
    parameter int unsigned C_FIFO_WIDTH   = 1,
    parameter int unsigned C_FIFO_DEPTH_X = 1
) (
    input  logic                    clk_i,
    input  logic                    resetb_i,
    input  logic                    clk_en_i,
    input  logic                    flush_i,
    input  logic                    push_i,
    input  logic [C_FIFO_WIDTH-1:0] wdata_i,
    input  logic                    pop_i,
    output logic [C_FIFO_WIDTH-1:0] rdata_o,
    output logic                    empty_o,
    output logic                    full_o
);

    localparam int unsigned DEPTH = 1 << C_FIFO_DEPTH_X;
    localparam int unsigned PTR_W = (C_FIFO_DEPTH_X > 0) ? C_FIFO_DEPTH_X : 1;
    localparam int unsigned CNT_W = C_FIFO_DEPTH_X + 1;

    logic [C_FIFO_WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]        wr_ptr_q;
    logic [PTR_W-1:0]        rd_ptr_q;
    logic [CNT_W-1:0]        count_q;
    logic                    do_push;
    logic                    do_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return ptr + 1'b1;
    endfunction

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clk_en_i) begin
            if (flush_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                if (do_push) begin
                    wr_ptr_q <= ptr_inc(wr_ptr_q);
                end
                if (do_pop) begin
                    rd_ptr_q <= ptr_inc(rd_ptr_q);
                end
                if (do_push && !do_pop) begin
                    count_q <= count_q + 1'b1;
                end else if (!do_push && do_pop) begin
                    count_q <= count_q - 1'b1;
                end
            end
        end
    end

    // Storage needs no reset: an entry is only observed once it has been written.
    always_ff @(posedge clk_i) begin
        if (clk_en_i && !flush_i && do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ibus_dbus_arb.sv
// Arbiter sharing one memory request/response port between the pre-fetch
// unit (I side) and the load/store unit (D side).
// Request path is combinational from the granted side to mreq*. D has priority,
// but after C_STARVE_MAX consecutive D grants with I waiting, I is forced.
// A stalled grant is locked to its side until accepted. Responses return in
// order and are steered by a tag tracker; a response with no outstanding
// request is consumed, dropped and flagged on the sticky proterr_o.
// Ports:
//   clk_i, resetb_i, clk_en_i   clock, async active-low reset, global enable
//   ireq*/irsp*                 I side request / response
//   dreq*/drsp*                 D side request (with wr/be/data) / response
//   mreq*/mrsp*                 shared memory request / response
//   proterr_o                   sticky protocol error
module ibus_dbus_arb
    import ibus_dbus_arb_pkg::*;
#(
    parameter int unsigned C_OUTSTANDING_X = 1,
    parameter int unsigned C_STARVE_MAX    = 4,
    parameter int unsigned XLEN            = 32
) (
    input  logic              clk_i,
    input  logic              resetb_i,
    input  logic              clk_en_i,
    input  logic              ireqvalid_i,
    output logic              ireqready_o,
    input  logic [1:0]        ireqhpl_i,
    input  logic [XLEN-1:0]   ireqaddr_i,
    output logic              irspvalid_o,
    input  logic              irspready_i,
    output logic              irsprerr_o,
    output logic [XLEN-1:0]   irspdata_o,
    input  logic              dreqvalid_i,
    output logic              dreqready_o,
    input  logic [1:0]        dreqhpl_i,
    input  logic [XLEN-1:0]   dreqaddr_i,
    input  logic              dreqwr_i,
    input  logic [XLEN/8-1:0] dreqbe_i,
    input  logic [XLEN-1:0]   dreqdata_i,
    output logic              drspvalid_o,
    input  logic              drspready_i,
    output logic              drsprerr_o,
    output logic [XLEN-1:0]   drspdata_o,
    output logic              mreqvalid_o,
    input  logic              mreqready_i,
    output logic [1:0]        mreqhpl_o,
    output logic [XLEN-1:0]   mreqaddr_o,
    output logic              mreqwr_o,
    output logic [XLEN/8-1:0] mreqbe_o,
    output logic [XLEN-1:0]   mreqdata_o,
    input  logic              mrspvalid_i,
    output logic              mrspready_o,
    input  logic              mrsprerr_i,
    input  logic [XLEN-1:0]   mrspdata_i,
    output logic              proterr_o
);

    arb_state_e          state_q;
    logic [STARVE_W-1:0] starve_q;
    logic                proterr_q;

    logic                sel_d;
    logic                gnt_valid;
    logic                req_acc;
    logic                tag_full;
    logic                tag_empty;
    logic [0:0]          tag_head;
    logic                head_is_d;
    logic                rsp_pop;
    logic                spurious;

    // Grant selection. A tracker that is full at the start of the cycle blocks
    // every grant, even if a response pops in the same cycle.
    always_comb begin
        sel_d     = 1'b0;
        gnt_valid = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (!tag_full) begin
                    if (dreqvalid_i && (starve_q < STARVE_W'(C_STARVE_MAX))) begin
                        sel_d     = 1'b1;
                        gnt_valid = 1'b1;
                    end else if (ireqvalid_i) begin
                        sel_d     = 1'b0;
                        gnt_valid = 1'b1;
                    end else if (dreqvalid_i) begin
                        sel_d     = 1'b1;
                        gnt_valid = 1'b1;
                    end
                end
            end
            StILock: begin
                sel_d     = 1'b0;
                gnt_valid = ireqvalid_i & ~tag_full;
            end
            StDLock: begin
                sel_d     = 1'b1;
                gnt_valid = dreqvalid_i & ~tag_full;
            end
            default: begin
                sel_d     = 1'b0;
                gnt_valid = 1'b0;
            end
        endcase
    end

    assign mreqvalid_o = gnt_valid & clk_en_i;
    assign req_acc     = mreqvalid_o & mreqready_i;
    assign ireqready_o = req_acc & ~sel_d;
    assign dreqready_o = req_acc & sel_d;

    // I fetches are always full-width reads.
    assign mreqhpl_o  = sel_d ? dreqhpl_i  : ireqhpl_i;
    assign mreqaddr_o = sel_d ? dreqaddr_i : ireqaddr_i;
    assign mreqwr_o   = sel_d & dreqwr_i;
    assign mreqbe_o   = sel_d ? dreqbe_i   : '1;
    assign mreqdata_o = sel_d ? dreqdata_i : '0;

    // Response steering from the oldest outstanding tag.
    assign head_is_d   = (tag_head[0] == ARB_SRC_D);
    assign irspvalid_o = clk_en_i & mrspvalid_i & ~tag_empty & ~head_is_d;
    assign drspvalid_o = clk_en_i & mrspvalid_i & ~tag_empty & head_is_d;
    assign irspdata_o  = mrspdata_i;
    assign irsprerr_o  = mrsprerr_i;
    assign drspdata_o  = mrspdata_i;
    assign drsprerr_o  = mrsprerr_i;

    // With nothing outstanding a response is accepted and discarded.
    assign mrspready_o = clk_en_i & (tag_empty ? mrspvalid_i
                                               : (head_is_d ? drspready_i : irspready_i));
    assign rsp_pop     = mrspvalid_i & mrspready_o & ~tag_empty;
    assign spurious    = clk_en_i & mrspvalid_i & tag_empty;

    assign proterr_o = proterr_q;

    ibus_dbus_arb_fifo #(
        .C_FIFO_WIDTH   (1),
        .C_FIFO_DEPTH_X (C_OUTSTANDING_X)
    ) u_tracker (
        .clk_i    (clk_i),
        .resetb_i (resetb_i),
        .clk_en_i (clk_en_i),
        .flush_i  (1'b0),
        .push_i   (req_acc),
        .wdata_i  (sel_d ? ARB_SRC_D : ARB_SRC_I),
        .pop_i    (rsp_pop),
        .rdata_o  (tag_head),
        .empty_o  (tag_empty),
        .full_o   (tag_full)
    );

    always_ff @(posedge clk_i or negedge resetb_i) begin
        if (!resetb_i) begin
            state_q   <= StIdle;
            starve_q  <= '0;
            proterr_q <= 1'b0;
        end else if (clk_en_i) begin
            if (spurious) begin
                proterr_q <= 1'b1;
            end

            // Counts D grants taken while I was kept waiting.
            if (dreqready_o && ireqvalid_i) begin
                starve_q <= starve_inc(starve_q);
            end else if (ireqready_o || !ireqvalid_i) begin
                starve_q <= '0;
            end

            unique case (state_q)
                StIdle: begin
                    if (gnt_valid && !mreqready_i) begin
                        state_q <= sel_d ? StDLock : StILock;
                    end
                end
                StILock, StDLock: begin
                    if (req_acc) begin
                        state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_ibus_dbus_arb.sv
module tb_ibus_dbus_arb;

    localparam int unsigned X     = 1;
    localparam int unsigned SMAX  = 4;
    localparam int unsigned XLEN  = 32;
    localparam int unsigned DEPTH = 1 << X;

    logic        clk;
    logic        resetb;
    logic        clk_en;
    logic        ireqvalid, ireqready, irspvalid, irspready, irsprerr;
    logic [1:0]  ireqhpl;
    logic [31:0] ireqaddr, irspdata;
    logic        dreqvalid, dreqready, dreqwr, drspvalid, drspready, drsprerr;
    logic [1:0]  dreqhpl;
    logic [31:0] dreqaddr, dreqdata, drspdata;
    logic [3:0]  dreqbe;
    logic        mreqvalid, mreqready, mreqwr, mrspvalid, mrspready, mrsprerr;
    logic [1:0]  mreqhpl;
    logic [31:0] mreqaddr, mreqdata, mrspdata;
    logic [3:0]  mreqbe;
    logic        proterr;

    int checks;
    int errors;

    // Reference model state for the randomized run.
    bit          tagq [$];
    logic [31:0] rdataq [$];
    bit          rerrq [$];

    ibus_dbus_arb #(
        .C_OUTSTANDING_X (X),
        .C_STARVE_MAX    (SMAX),
        .XLEN            (XLEN)
    ) dut (
        .clk_i       (clk),
        .resetb_i    (resetb),
        .clk_en_i    (clk_en),
        .ireqvalid_i (ireqvalid),
        .ireqready_o (ireqready),
        .ireqhpl_i   (ireqhpl),
        .ireqaddr_i  (ireqaddr),
        .irspvalid_o (irspvalid),
        .irspready_i (irspready),
        .irsprerr_o  (irsprerr),
        .irspdata_o  (irspdata),
        .dreqvalid_i (dreqvalid),
        .dreqready_o (dreqready),
        .dreqhpl_i   (dreqhpl),
        .dreqaddr_i  (dreqaddr),
        .dreqwr_i    (dreqwr),
        .dreqbe_i    (dreqbe),
        .dreqdata_i  (dreqdata),
        .drspvalid_o (drspvalid),
        .drspready_i (drspready),
        .drsprerr_o  (drsprerr),
        .drspdata_o  (drspdata),
        .mreqvalid_o (mreqvalid),
        .mreqready_i (mreqready),
        .mreqhpl_o   (mreqhpl),
        .mreqaddr_o  (mreqaddr),
        .mreqwr_o    (mreqwr),
        .mreqbe_o    (mreqbe),
        .mreqdata_o  (mreqdata),
        .mrspvalid_i (mrspvalid),
        .mrspready_o (mrspready),
        .mrsprerr_i  (mrsprerr),
        .mrspdata_i  (mrspdata),
        .proterr_o   (proterr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1);
    end

    // Inputs change 1 time unit after the rising edge; outputs are sampled 3 later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic drive_idle();
        clk_en    = 1'b1;
        ireqvalid = 1'b0; ireqhpl = 2'b00; ireqaddr = '0; irspready = 1'b0;
        dreqvalid = 1'b0; dreqhpl = 2'b00; dreqaddr = '0; dreqwr = 1'b0;
        dreqbe    = 4'h0; dreqdata = '0;  drspready = 1'b0;
        mreqready = 1'b0; mrspvalid = 1'b0; mrsprerr = 1'b0; mrspdata = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        resetb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetb = 1'b1;
    endtask

    task automatic test_reset();
        drive_idle();
        resetb = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        settle();
        checks++;
        if ({mreqvalid, ireqready, dreqready, irspvalid, drspvalid, mrspready, proterr}
            !== 7'b0) begin
            errors++;
            $display("FAIL reset_in: outputs %b want 0000000",
                     {mreqvalid, ireqready, dreqready, irspvalid, drspvalid, mrspready, proterr});
        end
        #1 resetb = 1'b1;
        tick();
        settle();
        checks++;
        if ({mreqvalid, ireqready, dreqready, irspvalid, drspvalid, mrspready, proterr}
            !== 7'b0) begin
            errors++;
            $display("FAIL reset_out: outputs %b want 0000000",
                     {mreqvalid, ireqready, dreqready, irspvalid, drspvalid, mrspready, proterr});
        end
    endtask

    // Four fetches with an always-ready memory of latency one.
    task automatic test_i_only();
        int nrsp;
        logic [31:0] exp_data;
        do_reset();
        nrsp = 0;
        mreqready = 1'b1;
        irspready = 1'b1;
        drspready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            ireqvalid = (k < 4);
            ireqaddr  = 32'(4 * k);
            ireqhpl   = 2'b11;
            mrspvalid = (k >= 1) && (k <= 4);
            exp_data  = 32'h1000 + 32'(4 * (k - 1));
            mrspdata  = exp_data;
            settle();
            if (k < 4) begin
                checks++;
                if ({mreqvalid, ireqready, dreqready, mreqwr, mreqhpl, mreqbe, mreqaddr, mreqdata}
                    !== {4'b1100, 2'b11, 4'hf, 32'(4 * k), 32'h0}) begin
                    errors++;
                    $display("FAIL ionly_req%0d: v/ir/dr/wr %b addr %h be %h got, want 1100 addr %h be f",
                             k, {mreqvalid, ireqready, dreqready, mreqwr}, mreqaddr, mreqbe,
                             32'(4 * k));
                end
            end
            checks++;
            if ({irspvalid, drspvalid} !== {mrspvalid, 1'b0}) begin
                errors++;
                $display("FAIL ionly_rspv%0d: irsp/drsp valid %b want %b", k,
                         {irspvalid, drspvalid}, {mrspvalid, 1'b0});
            end
            if (mrspvalid) begin
                checks++;
                if ({mrspready, irspdata} !== {1'b1, exp_data}) begin
                    errors++;
                    $display("FAIL ionly_rspd%0d: ready %b data %h want 1 %h", k, mrspready,
                             irspdata, exp_data);
                end
            end
            if (irspvalid === 1'b1) nrsp++;
            tick();
        end
        drive_idle();
        settle();
        checks++;
        if ({nrsp, proterr} !== {32'd4, 1'b0}) begin
            errors++;
            $display("FAIL ionly_count: responses %0d proterr %b want 4 0", nrsp, proterr);
        end
    endtask

    // Both sides request every cycle; expect D,D,D,D,I,D,D,D,D,I.
    task automatic test_starve();
        bit exp_d;
        bit prev_d;
        do_reset();
        ireqvalid = 1'b1; ireqaddr = 32'h100;
        dreqvalid = 1'b1; dreqaddr = 32'h200;
        mreqready = 1'b1; irspready = 1'b1; drspready = 1'b1;
        prev_d = 1'b0;
        for (int k = 0; k < 10; k++) begin
            mrspvalid = (k > 0);
            exp_d = ((k % 5) != 4);
            settle();
            checks++;
            if ({dreqready, ireqready, mreqaddr} !==
                {exp_d, !exp_d, exp_d ? 32'h200 : 32'h100}) begin
                errors++;
                $display("FAIL starve_grant%0d: dr/ir %b addr %h want %b%b", k,
                         {dreqready, ireqready}, mreqaddr, exp_d, !exp_d);
            end
            if (k > 0) begin
                checks++;
                if ({drspvalid, irspvalid} !== {prev_d, !prev_d}) begin
                    errors++;
                    $display("FAIL starve_rsp%0d: drsp/irsp %b want %b%b", k,
                             {drspvalid, irspvalid}, prev_d, !prev_d);
                end
            end
            prev_d = exp_d;
            tick();
        end
        ireqvalid = 1'b0;
        dreqvalid = 1'b0;
        settle();
        checks++;
        if ({drspvalid, irspvalid, mreqvalid} !== 3'b010) begin
            errors++;
            $display("FAIL starve_drain: drsp/irsp/mreqv %b want 010",
                     {drspvalid, irspvalid, mreqvalid});
        end
        tick();
        mrspvalid = 1'b0;
    endtask

    // A stalled D grant stays locked while I starts requesting.
    task automatic test_lock();
        do_reset();
        dreqvalid = 1'b1; dreqaddr = 32'h300; dreqwr = 1'b1;
        dreqbe = 4'h3; dreqdata = 32'hdeadbeef; dreqhpl = 2'b01;
        ireqaddr = 32'h400;
        for (int k = 0; k < 4; k++) begin
            ireqvalid = (k >= 1);
            mreqready = (k == 3);
            settle();
            checks++;
            if ({mreqvalid, ireqready, dreqready, mreqwr, mreqhpl, mreqbe, mreqaddr, mreqdata}
                !== {1'b1, 1'b0, (k == 3), 1'b1, 2'b01, 4'h3, 32'h300, 32'hdeadbeef}) begin
                errors++;
                $display("FAIL lock_d%0d: v/ir/dr/wr %b be %h addr %h data %h want 10%b1 3 300",
                         k, {mreqvalid, ireqready, dreqready, mreqwr}, mreqbe, mreqaddr,
                         mreqdata, (k == 3));
            end
            tick();
        end
        dreqvalid = 1'b0;
        settle();
        checks++;
        if ({ireqready, dreqready, mreqwr, mreqbe, mreqaddr, mreqdata}
            !== {3'b100, 4'hf, 32'h400, 32'h0}) begin
            errors++;
            $display("FAIL lock_i: ir/dr/wr %b be %h addr %h data %h want 100 f 400 0",
                     {ireqready, dreqready, mreqwr}, mreqbe, mreqaddr, mreqdata);
        end
        tick();
        ireqvalid = 1'b0;
    endtask

    // Two outstanding fill the tracker; a same-cycle pop does not free a slot.
    task automatic test_full();
        bit exp_v;
        do_reset();
        ireqvalid = 1'b1; ireqaddr = 32'h500;
        mreqready = 1'b1; irspready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            mrspvalid = (k == 3);
            exp_v = (k < 2) || (k == 4);
            settle();
            checks++;
            if ({mreqvalid, ireqready} !== {exp_v, exp_v}) begin
                errors++;
                $display("FAIL full_req%0d: mreqv/ir %b want %b%b", k, {mreqvalid, ireqready},
                         exp_v, exp_v);
            end
            if (k == 3) begin
                checks++;
                if ({irspvalid, mrspready} !== 2'b11) begin
                    errors++;
                    $display("FAIL full_pop: irspv/mrspr %b want 11", {irspvalid, mrspready});
                end
            end
            tick();
        end
        ireqvalid = 1'b0;
        mrspvalid = 1'b0;
    endtask

    // I, D, I issued; responses steered in order with rerr and backpressure.
    task automatic test_interleave();
        do_reset();
        mreqready = 1'b1; irspready = 1'b1; drspready = 1'b1;
        ireqvalid = 1'b1; ireqaddr = 32'h600;
        settle();
        checks++;
        if ({ireqready, dreqready} !== 2'b10) begin
            errors++;
            $display("FAIL inter_i0: ir/dr %b want 10", {ireqready, dreqready});
        end
        tick();
        ireqvalid = 1'b0;
        dreqvalid = 1'b1; dreqaddr = 32'h700;
        settle();
        checks++;
        if ({ireqready, dreqready} !== 2'b01) begin
            errors++;
            $display("FAIL inter_d: ir/dr %b want 01", {ireqready, dreqready});
        end
        tick();
        dreqvalid = 1'b0;
        ireqvalid = 1'b1; ireqaddr = 32'h604;
        mrspvalid = 1'b1; mrsprerr = 1'b0; mrspdata = 32'haaaa0000;
        settle();
        checks++;
        if ({mreqvalid, irspvalid, drspvalid, mrspready, irsprerr, irspdata}
            !== {4'b0101, 1'b0, 32'haaaa0000}) begin
            errors++;
            $display("FAIL inter_r0: mreqv/irsp/drsp/mrspr %b rerr %b data %h want 0101 0 aaaa0000",
                     {mreqvalid, irspvalid, drspvalid, mrspready}, irsprerr, irspdata);
        end
        tick();
        mrsprerr = 1'b1; mrspdata = 32'hbbbb0000; drspready = 1'b0;
        settle();
        checks++;
        if ({ireqready, irspvalid, drspvalid, mrspready, drsprerr, drspdata}
            !== {4'b1010, 1'b1, 32'hbbbb0000}) begin
            errors++;
            $display("FAIL inter_r1: ir/irsp/drsp/mrspr %b rerr %b data %h want 1010 1 bbbb0000",
                     {ireqready, irspvalid, drspvalid, mrspready}, drsprerr, drspdata);
        end
        tick();
        ireqvalid = 1'b0;
        settle();
        checks++;
        if ({drspvalid, mrspready} !== 2'b10) begin
            errors++;
            $display("FAIL inter_stall: drsp/mrspr %b want 10", {drspvalid, mrspready});
        end
        tick();
        drspready = 1'b1;
        settle();
        checks++;
        if ({drspvalid, mrspready, drsprerr} !== 3'b111) begin
            errors++;
            $display("FAIL inter_r1go: drsp/mrspr/rerr %b want 111",
                     {drspvalid, mrspready, drsprerr});
        end
        tick();
        mrsprerr = 1'b0; mrspdata = 32'hcccc0000;
        settle();
        checks++;
        if ({irspvalid, drspvalid, mrspready, irsprerr, irspdata}
            !== {4'b1010, 32'hcccc0000}) begin
            errors++;
            $display("FAIL inter_r2: irsp/drsp/mrspr/rerr %b data %h want 1010 cccc0000",
                     {irspvalid, drspvalid, mrspready, irsprerr}, irspdata);
        end
        tick();
        mrspvalid = 1'b0;
        settle();
        checks++;
        if ({proterr, irspvalid, drspvalid} !== 3'b000) begin
            errors++;
            $display("FAIL inter_end: proterr/irsp/drsp %b want 000",
                     {proterr, irspvalid, drspvalid});
        end
    endtask

    // Response with nothing outstanding: dropped and flagged until reset.
    task automatic test_spurious();
        do_reset();
        clk_en = 1'b0;
        mrspvalid = 1'b1; mrspdata = 32'h12345678;
        tick();
        tick();
        settle();
        checks++;
        if (proterr !== 1'b0) begin
            errors++;
            $display("FAIL spur_hold: proterr %b want 0 while clock enable low", proterr);
        end
        clk_en = 1'b1;
        settle();
        checks++;
        if ({mrspready, irspvalid, drspvalid, proterr} !== 4'b1000) begin
            errors++;
            $display("FAIL spur_rsp: mrspr/irsp/drsp/proterr %b want 1000",
                     {mrspready, irspvalid, drspvalid, proterr});
        end
        tick();
        mrspvalid = 1'b0;
        settle();
        checks++;
        if (proterr !== 1'b1) begin
            errors++;
            $display("FAIL spur_set: proterr %b want 1", proterr);
        end
        repeat (3) tick();
        checks++;
        if (proterr !== 1'b1) begin
            errors++;
            $display("FAIL spur_sticky: proterr %b want 1", proterr);
        end
        do_reset();
        settle();
        checks++;
        if (proterr !== 1'b0) begin
            errors++;
            $display("FAIL spur_clear: proterr %b want 0 after reset", proterr);
        end
    endtask

    // Random traffic against a transaction-level model of the arbitration rules.
    task automatic test_random();
        bit   i_pend, d_pend, full, nonempty, head, g, side, acc, e_mrdy, ivalid;
        int   lock;  // 0 none, 1 locked to I, 2 locked to D
        int   cnt;
        logic [70:0] exp_pl;
        do_reset();
        tagq.delete(); rdataq.delete(); rerrq.delete();
        i_pend = 0; d_pend = 0; lock = 0; cnt = 0;
        for (int c = 0; c < 3000; c++) begin
            if (!i_pend && $urandom_range(0, 3) != 0) begin
                i_pend = 1;
                ireqaddr = $urandom & 32'hffff_fffc;
                ireqhpl = 2'($urandom);
            end
            if (!d_pend && $urandom_range(0, 3) != 0) begin
                d_pend = 1;
                dreqaddr = $urandom;
                dreqhpl = 2'($urandom);
                dreqwr = 1'($urandom);
                dreqbe = 4'($urandom);
                dreqdata = $urandom;
            end
            ireqvalid = i_pend;
            dreqvalid = d_pend;
            mreqready = ($urandom_range(0, 2) != 0);
            irspready = ($urandom_range(0, 3) != 0);
            drspready = ($urandom_range(0, 3) != 0);
            if (rdataq.size() > 0 && $urandom_range(0, 1) == 1) begin
                mrspvalid = 1'b1;
                mrspdata = rdataq[0];
                mrsprerr = rerrq[0];
            end else begin
                mrspvalid = 1'b0;
                mrspdata = $urandom;
                mrsprerr = 1'($urandom);
            end
            settle();

            full = (tagq.size() == DEPTH);
            g = 0;
            side = 0;
            if (lock == 0) begin
                if (!full) begin
                    if (d_pend && cnt < SMAX) begin g = 1; side = 1; end
                    else if (i_pend) begin g = 1; side = 0; end
                    else if (d_pend) begin g = 1; side = 1; end
                end
            end else begin
                side = (lock == 2);
                g = (side ? d_pend : i_pend) && !full;
            end
            acc = g && mreqready;
            nonempty = (tagq.size() > 0);
            head = nonempty ? tagq[0] : 1'b0;
            e_mrdy = nonempty ? (head ? drspready : irspready) : mrspvalid;

            checks++;
            if ({mreqvalid, ireqready, dreqready} !== {g, acc && !side, acc && side}) begin
                errors++;
                $display("FAIL rand_grant c%0d: v/ir/dr %b want %b%b%b", c,
                         {mreqvalid, ireqready, dreqready}, g, acc && !side, acc && side);
            end
            if (g) begin
                exp_pl = side ? {dreqaddr, dreqhpl, dreqwr, dreqbe, dreqdata}
                              : {ireqaddr, ireqhpl, 1'b0, 4'hf, 32'h0};
                checks++;
                if ({mreqaddr, mreqhpl, mreqwr, mreqbe, mreqdata} !== exp_pl) begin
                    errors++;
                    $display("FAIL rand_payload c%0d: got %h want %h", c,
                             {mreqaddr, mreqhpl, mreqwr, mreqbe, mreqdata}, exp_pl);
                end
            end
            checks++;
            if ({irspvalid, drspvalid, mrspready, proterr} !==
                {mrspvalid && nonempty && !head, mrspvalid && nonempty && head, e_mrdy, 1'b0})
            begin
                errors++;
                $display("FAIL rand_rsp c%0d: irsp/drsp/mrspr/perr %b want %b%b%b0", c,
                         {irspvalid, drspvalid, mrspready, proterr},
                         mrspvalid && nonempty && !head, mrspvalid && nonempty && head, e_mrdy);
            end
            if (mrspvalid && nonempty) begin
                checks++;
                if (head ? ({drspdata, drsprerr} !== {rdataq[0], rerrq[0]})
                         : ({irspdata, irsprerr} !== {rdataq[0], rerrq[0]})) begin
                    errors++;
                    $display("FAIL rand_rdata c%0d: got %h/%b want %h/%b", c,
                             head ? drspdata : irspdata, head ? drsprerr : irsprerr,
                             rdataq[0], rerrq[0]);
                end
            end

            ivalid = i_pend;
            if (mrspvalid && e_mrdy && nonempty) begin
                void'(tagq.pop_front());
                void'(rdataq.pop_front());
                void'(rerrq.pop_front());
            end
            if (acc) begin
                tagq.push_back(side);
                rdataq.push_back($urandom);
                rerrq.push_back(1'($urandom));
                if (side) d_pend = 0; else i_pend = 0;
                lock = 0;
            end else if (lock == 0 && g) begin
                lock = side ? 2 : 1;
            end
            if (acc && side && ivalid) cnt = (cnt < 15) ? cnt + 1 : 15;
            else if ((acc && !side) || !ivalid) cnt = 0;
            tick();
        end
        drive_idle();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        resetb = 1'b0;
        drive_idle();
        test_reset();
        test_i_only();
        test_starve();
        test_lock();
        test_full();
        test_interleave();
        test_spurious();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
